// File: rtl/noise.sv
// RP2A03-style APU noise channel: 15-bit LFSR gated by envelope and length counter.
// Optional short (93-step) LFSR mode is compiled in by defining NOISE_SHORT_MODE_EN.
module noise #(
  parameter logic [14:0] LFSR_SEED = 15'h0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_240hz,
  input  logic       enable_120hz,
  input  logic [7:0] reg_400C,
  input  logic [7:0] reg_400E,
  input  logic [7:0] reg_400F,
  input  logic       reg_change,
  output logic [3:0] noise_out
);

  localparam int unsigned LFSR_W  = 15;
  localparam int unsigned TIMER_W = 12;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned VOL_W   = 4;

  localparam logic [TIMER_W-1:0] PERIOD_LUT [16] = '{
    12'd4,   12'd8,   12'd16,  12'd32,  12'd64,   12'd96,   12'd128,  12'd160,
    12'd202, 12'd254, 12'd380, 12'd508, 12'd762,  12'd1016, 12'd2034, 12'd4068
  };

  localparam logic [LEN_W-1:0] LEN_LUT [32] = '{
    8'd10, 8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,  8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12, 8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  logic [LFSR_W-1:0]  lfsr_q,    lfsr_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic [LEN_W-1:0]   length_q,  length_d;
  logic [VOL_W-1:0]   decay_q,   decay_d;
  logic [VOL_W-1:0]   divider_q, divider_d;
  logic               start_q,   start_d;
  logic [VOL_W-1:0]   noise_q,   noise_d;

  logic               halt_loop;
  logic               const_vol;
  logic [VOL_W-1:0]   volume;
  logic               short_mode;
  logic               lfsr_fb;
  logic               unused_reg_bits;

  assign halt_loop = reg_400C[5];
  assign const_vol = reg_400C[4];
  assign volume    = reg_400C[3:0];

`ifdef NOISE_SHORT_MODE_EN
  assign short_mode      = reg_400E[7];
  assign unused_reg_bits = ^{reg_400C[7:6], reg_400E[6:4], reg_400F[2:0]};
`else
  assign short_mode      = 1'b0;
  assign unused_reg_bits = ^{reg_400C[7:6], reg_400E[7:4], reg_400F[2:0]};
`endif

  assign lfsr_fb = lfsr_q[0] ^ (short_mode ? lfsr_q[6] : lfsr_q[1]);

  // Next-state logic for timer/LFSR, length counter, envelope and output sample
  always_comb begin
    timer_d   = timer_q;
    lfsr_d    = lfsr_q;
    length_d  = length_q;
    decay_d   = decay_q;
    divider_d = divider_q;
    start_d   = start_q;
    noise_d   = noise_q;

    // Period index is sampled only on reload, so a new P waits for the current count
    if (timer_q == '0) begin
      timer_d = PERIOD_LUT[reg_400E[3:0]] - TIMER_W'(1);
      lfsr_d  = {lfsr_fb, lfsr_q[LFSR_W-1:1]};
    end else begin
      timer_d = timer_q - TIMER_W'(1);
    end

    if (reg_change) begin
      length_d = LEN_LUT[reg_400F[7:3]];
    end else if (enable_120hz && !halt_loop && (length_q != '0)) begin
      length_d = length_q - LEN_W'(1);
    end

    if (enable_240hz) begin
      if (start_q) begin
        start_d   = 1'b0;
        decay_d   = VOL_W'(15);
        divider_d = volume;
      end else if (divider_q == '0) begin
        divider_d = volume;
        if (decay_q != '0) begin
          decay_d = decay_q - VOL_W'(1);
        end else if (halt_loop) begin
          decay_d = VOL_W'(15);
        end
      end else begin
        divider_d = divider_q - VOL_W'(1);
      end
    end

    // A write restarts the envelope after any same-cycle tick has used the old flag
    if (reg_change) begin
      start_d = 1'b1;
    end

    if (lfsr_q[0] || (length_q == '0)) begin
      noise_d = '0;
    end else begin
      noise_d = const_vol ? volume : decay_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q    <= LFSR_SEED;
      timer_q   <= '0;
      length_q  <= '0;
      decay_q   <= '0;
      divider_q <= '0;
      start_q   <= 1'b0;
      noise_q   <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      timer_q   <= timer_d;
      length_q  <= length_d;
      decay_q   <= decay_d;
      divider_q <= divider_d;
      start_q   <= start_d;
      noise_q   <= noise_d;
    end
  end

  assign noise_out = noise_q;

endmodule
